dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Dispatch controller between the decode stage and the out-of-order back end. Accepts one decoded instruction per cycle over a valid/ready handshake, allocates a reorder-buffer (ROB) tag and a reservation-station slot in the ALU or LSU station, and stalls decode when any required resource is full. Tracks ROB and station occupancy from commit and issue-free pulses, and recovers to an empty state on pipeline flush.

## Interface
- ROB_DEPTH, 16, ROB entries; power of two, ≥ 4
- ALU_RS_DEPTH, 4, ALU reservation-station entries
- LSU_RS_DEPTH, 4, load/store reservation-station entries
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- dec_valid  in  1  decode presents an instruction
- dec_class  in  2  00 NOP, 01 ALU (R/I type), 10 LW, 11 SW; stable while dec_valid
- dec_ready  out  1  dispatch accepts this cycle (combinational)
- rob_alloc  out  1  registered pulse: ROB entry allocated
- rob_tag  out  log2(ROB_DEPTH)  tag of allocated entry, valid with rob_alloc
- alu_rs_alloc  out  1  registered pulse: write ALU station
- lsu_rs_alloc  out  1  registered pulse: write LSU station
- alu_rs_free  in  1  one ALU station entry issued this cycle
- lsu_rs_free  in  1  one LSU station entry issued this cycle
- rob_commit  in  1  ROB head retired this cycle
- flush  in  1  discard all in-flight instructions
- rob_count  out  log2(ROB_DEPTH)+1  ROB occupancy
- rob_full, rob_empty  out  1  rob_count == ROB_DEPTH / == 0
- stall_cnt  out  16  cycles with dec_valid && !dec_ready, saturating at 0xFFFF

## Operation
- States: RUN, STALL, RECOVER. Reset state RUN.
- dec_ready = (state != RECOVER) && !flush && !rob_full && class check: ALU needs alu_cnt < ALU_RS_DEPTH; LW/SW need lsu_cnt < LSU_RS_DEPTH; NOP needs ROB only.
- Fullness uses current registered counts only; same-cycle frees/commits do not bypass into dec_ready.
- Accept = dec_valid && dec_ready at a rising edge: tail tag issued, tail increments mod ROB_DEPTH, rob_count +1, class station count +1.
- NOP occupies a ROB entry, no station entry.
- rob_commit: rob_count −1; ignored when rob_count == 0. Accept + commit same edge: count unchanged, tail still advances.
- alu_rs_free / lsu_rs_free: station count −1; ignored at 0. Accept + free on same station same edge: count unchanged.
- Transitions: RUN→STALL when dec_valid && !dec_ready; STALL→RUN when dec_ready or !dec_valid; any→RECOVER on flush; RECOVER→RUN after exactly one cycle (unless flush still high, which holds RECOVER).
- Flush edge: tail, rob_count, alu_cnt, lsu_cnt cleared to 0; any accept presented that cycle is dropped (dec_ready already 0); alloc pulses of the following cycle forced 0. Commit/free inputs on the flush edge are ignored.
- stall_cnt increments every edge with dec_valid && !dec_ready (including RECOVER); not cleared by flush, only by rst.

## Timing
- Reset (async): state RUN; rob_alloc, alu_rs_alloc, lsu_rs_alloc, rob_tag, rob_count, stall_cnt all 0; rob_empty 1, rob_full 0; tail 0. dec_ready = dec_valid-independent-resources-free → 1 after reset release (counts 0).
- Allocation latency: accept at edge N → rob_alloc, rob_tag, station alloc pulse high for the cycle after edge N, exactly one cycle.
- Back-to-back accepts: one per cycle, tags consecutive, wrap ROB_DEPTH−1 → 0.
- Counts and flags visible the cycle after the causing edge.
- Freed resource becomes available to dec_ready one cycle after the free pulse.

## Test plan
- Reset release, 16 consecutive ALU/NOP mix with alu_rs_free each cycle → tags 0..15, rob_full=1 after 16th, dec_ready=0, stall_cnt counts each waiting cycle.
- 5 back-to-back LW with no lsu_rs_free → first 4 accepted, 5th stalls (state STALL); lsu_rs_free pulse → 5th accepted one cycle later, lsu_rs_alloc pulse the cycle after.
- Full ROB, dec_valid + rob_commit same cycle → not accepted that cycle (no bypass); accepted next cycle, rob_count stays 16.
- Tag wrap: 20 accepts with commit each cycle after the 4th → tags 0..15, 0..3; rob_count never exceeds 4.
- Flush during STALL with rob_count=9 → next cycle rob_count=0, RECOVER with dec_ready=0 one cycle, then first accept gets tag 0; stall_cnt retained.
- rst asserted mid-stream with alloc pulse high → all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// ============================================================================
// Module      : dispatch_ctrl
// Description : Decode-to-backend dispatch; allocates ROB tags and ALU/LSU
//               reservation-station slots, stalls decode on full resources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_ctrl #(
  parameter int ROB_DEPTH    = 16,
  parameter int ALU_RS_DEPTH = 4,
  parameter int LSU_RS_DEPTH = 4,
  localparam int TW = $clog2(ROB_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  input  logic [1:0]    dec_class,
  output logic          dec_ready,
  output logic          rob_alloc,
  output logic [TW-1:0] rob_tag,
  output logic          alu_rs_alloc,
  output logic          lsu_rs_alloc,
  input  logic          alu_rs_free,
  input  logic          lsu_rs_free,
  input  logic          rob_commit,
  input  logic          flush,
  output logic [TW:0]   rob_count,
  output logic          rob_full,
  output logic          rob_empty,
  output logic [15:0]   stall_cnt
);

  localparam int AW = $clog2(ALU_RS_DEPTH + 1);
  localparam int LW = $clog2(LSU_RS_DEPTH + 1);

  localparam logic [TW:0]   c_ROB_MAX = (TW+1)'(ROB_DEPTH);
  localparam logic [AW-1:0] c_ALU_MAX = AW'(ALU_RS_DEPTH);
  localparam logic [LW-1:0] c_LSU_MAX = LW'(LSU_RS_DEPTH);

  localparam logic [1:0] c_CLS_NOP = 2'b00;
  localparam logic [1:0] c_CLS_ALU = 2'b01;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tail;
  logic [AW-1:0]   r_alu_cnt;
  logic [LW-1:0]   r_lsu_cnt;

  logic w_class_ok;
  logic w_accept;
  logic w_is_alu;
  logic w_is_lsu;
  logic w_commit;
  logic w_alu_dec;
  logic w_lsu_dec;
  logic w_alu_inc;
  logic w_lsu_inc;
  logic w_stall;

  assign rob_full  = (rob_count == c_ROB_MAX);
  assign rob_empty = (rob_count == '0);

  assign w_is_alu = (dec_class == c_CLS_ALU);
  assign w_is_lsu = dec_class[1];

  always_comb begin
    w_class_ok = 1'b1;
    if (w_is_alu)
      w_class_ok = (r_alu_cnt < c_ALU_MAX);
    else if (w_is_lsu)
      w_class_ok = (r_lsu_cnt < c_LSU_MAX);
    else if (dec_class == c_CLS_NOP)
      w_class_ok = 1'b1;
  end

  // Readiness looks only at registered counts; frees and commits land next cycle.
  assign dec_ready = (r_state != RECOVER) && !flush && !rob_full && w_class_ok;

  assign w_accept  = dec_valid && dec_ready;
  assign w_stall   = dec_valid && !dec_ready;
  assign w_commit  = rob_commit  && (rob_count != '0);
  assign w_alu_dec = alu_rs_free && (r_alu_cnt != '0);
  assign w_lsu_dec = lsu_rs_free && (r_lsu_cnt != '0);
  assign w_alu_inc = w_accept && w_is_alu;
  assign w_lsu_inc = w_accept && w_is_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_tail       <= '0;
      r_alu_cnt    <= '0;
      r_lsu_cnt    <= '0;
      rob_count    <= '0;
      rob_alloc    <= 1'b0;
      rob_tag      <= '0;
      alu_rs_alloc <= 1'b0;
      lsu_rs_alloc <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (w_stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;

      if (flush) begin
        r_state      <= RECOVER;
        r_tail       <= '0;
        r_alu_cnt    <= '0;
        r_lsu_cnt    <= '0;
        rob_count    <= '0;
        rob_alloc    <= 1'b0;
        alu_rs_alloc <= 1'b0;
        lsu_rs_alloc <= 1'b0;
      end else begin
        rob_alloc    <= w_accept;
        alu_rs_alloc <= w_alu_inc;
        lsu_rs_alloc <= w_lsu_inc;

        if (w_accept) begin
          rob_tag <= r_tail;
          r_tail  <= r_tail + 1'b1;
        end

        if (w_accept && !w_commit)
          rob_count <= rob_count + 1'b1;
        else if (!w_accept && w_commit)
          rob_count <= rob_count - 1'b1;

        if (w_alu_inc && !w_alu_dec)
          r_alu_cnt <= r_alu_cnt + 1'b1;
        else if (!w_alu_inc && w_alu_dec)
          r_alu_cnt <= r_alu_cnt - 1'b1;

        if (w_lsu_inc && !w_lsu_dec)
          r_lsu_cnt <= r_lsu_cnt + 1'b1;
        else if (!w_lsu_inc && w_lsu_dec)
          r_lsu_cnt <= r_lsu_cnt - 1'b1;

        case (r_state)
          RUN:     if (w_stall) r_state <= STALL;
          STALL:   if (dec_ready || !dec_valid) r_state <= RUN;
          RECOVER: r_state <= RUN;
          default: r_state <= RUN;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
// ============================================================================
// Module      : tb_dispatch_ctrl
// Description : Directed self-checking bench for dispatch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dispatch_ctrl;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [1:0]  dec_class;
  logic        dec_ready;
  logic        rob_alloc;
  logic [3:0]  rob_tag;
  logic        alu_rs_alloc;
  logic        lsu_rs_alloc;
  logic        alu_rs_free;
  logic        lsu_rs_free;
  logic        rob_commit;
  logic        flush;
  logic [4:0]  rob_count;
  logic        rob_full;
  logic        rob_empty;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] c_NOP = 2'b00;
  localparam logic [1:0] c_ALU = 2'b01;
  localparam logic [1:0] c_LWC = 2'b10;

  dispatch_ctrl #(
    .ROB_DEPTH   (16),
    .ALU_RS_DEPTH(4),
    .LSU_RS_DEPTH(4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid   (dec_valid),
    .dec_class   (dec_class),
    .dec_ready   (dec_ready),
    .rob_alloc   (rob_alloc),
    .rob_tag     (rob_tag),
    .alu_rs_alloc(alu_rs_alloc),
    .lsu_rs_alloc(lsu_rs_alloc),
    .alu_rs_free (alu_rs_free),
    .lsu_rs_free (lsu_rs_free),
    .rob_commit  (rob_commit),
    .flush       (flush),
    .rob_count   (rob_count),
    .rob_full    (rob_full),
    .rob_empty   (rob_empty),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [1:0] cls);
    dec_valid = v;
    dec_class = cls;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dec_valid = 1'b0;
    dec_class = c_NOP;
    alu_rs_free = 1'b0;
    lsu_rs_free = 1'b0;
    rob_commit = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_alloc", 32'(rob_alloc), 32'd0);
    check("rst_count", 32'(rob_count), 32'd0);
    check("rst_empty", 32'(rob_empty), 32'd1);
    check("rst_full",  32'(rob_full),  32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_ready", 32'(dec_ready), 32'd1);
    #2 rst = 1'b0;
    step();

    // 16 ALU/NOP accepts with ALU frees every cycle
    alu_rs_free = 1'b1;
    for (int i = 0; i < 16; i++) begin
      present(1'b1, (i % 2 == 0) ? c_ALU : c_NOP);
      check("fill_ready", 32'(dec_ready), 32'd1);
      step();
      check("fill_alloc", 32'(rob_alloc), 32'd1);
      check("fill_tag",   32'(rob_tag),   32'(i));
      check("fill_alu",   32'(alu_rs_alloc), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    alu_rs_free = 1'b0;
    check("full_count", 32'(rob_count), 32'd16);
    check("full_flag",  32'(rob_full),  32'd1);
    check("full_empty", 32'(rob_empty), 32'd0);
    present(1'b1, c_ALU);
    check("full_ready", 32'(dec_ready), 32'd0);
    step(); step(); step();
    check("full_noalloc", 32'(rob_alloc), 32'd0);
    check("full_stall",   32'(stall_cnt), 32'd3);

    // Commit on a full ROB does not bypass into dec_ready
    rob_commit = 1'b1;
    present(1'b1, c_NOP);
    check("byp_ready", 32'(dec_ready), 32'd0);
    step();
    rob_commit = 1'b0;
    check("byp_count", 32'(rob_count), 32'd15);
    check("byp_stall", 32'(stall_cnt), 32'd4);
    check("byp_noalloc", 32'(rob_alloc), 32'd0);
    #1;
    check("byp_ready2", 32'(dec_ready), 32'd1);
    step();
    check("byp_alloc", 32'(rob_alloc), 32'd1);
    check("byp_tag",   32'(rob_tag),   32'd0);
    check("byp_count2", 32'(rob_count), 32'd16);

    // Flush clears occupancy and blocks dispatch for one cycle
    dec_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_count", 32'(rob_count), 32'd0);
    check("fl_empty", 32'(rob_empty), 32'd1);
    check("fl_alloc", 32'(rob_alloc), 32'd0);
    present(1'b0, c_NOP);
    check("fl_recover_ready", 32'(dec_ready), 32'd0);
    step();
    check("fl_run_ready", 32'(dec_ready), 32'd1);
    check("fl_stall", 32'(stall_cnt), 32'd4);

    // Five LW: four fill the LSU station, the fifth waits for a free
    for (int i = 0; i < 4; i++) begin
      present(1'b1, c_LWC);
      check("lw_ready", 32'(dec_ready), 32'd1);
      step();
      check("lw_lsu", 32'(lsu_rs_alloc), 32'd1);
      check("lw_tag", 32'(rob_tag), 32'(i));
    end
    present(1'b1, c_LWC);
    check("lw5_ready", 32'(dec_ready), 32'd0);
    step();
    check("lw5_noalloc", 32'(rob_alloc), 32'd0);
    check("lw5_stall", 32'(stall_cnt), 32'd5);
    lsu_rs_free = 1'b1;
    #1;
    check("lw5_free_ready", 32'(dec_ready), 32'd0);
    step();
    lsu_rs_free = 1'b0;
    #1;
    check("lw5_ready2", 32'(dec_ready), 32'd1);
    step();
    check("lw5_lsu",   32'(lsu_rs_alloc), 32'd1);
    check("lw5_tag",   32'(rob_tag),   32'd4);
    check("lw5_count", 32'(rob_count), 32'd5);
    check("lw5_stall2", 32'(stall_cnt), 32'd6);

    // Build rob_count 9, stall on LW, then flush during the stall
    for (int i = 0; i < 4; i++) begin
      present(1'b1, c_NOP);
      step();
      check("nop_tag", 32'(rob_tag), 32'(5 + i));
      check("nop_lsu", 32'(lsu_rs_alloc), 32'd0);
    end
    present(1'b1, c_LWC);
    step();
    check("st_count", 32'(rob_count), 32'd9);
    check("st_stall", 32'(stall_cnt), 32'd7);
    flush = 1'b1;
    #1;
    check("st_fl_ready", 32'(dec_ready), 32'd0);
    step();
    flush = 1'b0;
    check("st_fl_count", 32'(rob_count), 32'd0);
    check("st_fl_alloc", 32'(rob_alloc), 32'd0);
    check("st_fl_stall", 32'(stall_cnt), 32'd8);
    #1;
    check("st_rec_ready", 32'(dec_ready), 32'd0);
    step();
    check("st_rec_stall", 32'(stall_cnt), 32'd9);
    check("st_run_ready", 32'(dec_ready), 32'd1);
    step();
    check("st_tag0", 32'(rob_tag), 32'd0);
    check("st_lsu",  32'(lsu_rs_alloc), 32'd1);
    check("st_stall2", 32'(stall_cnt), 32'd9);
    dec_valid = 1'b0;

    // Tag wrap with commits after the fourth accept
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      rob_commit = (i >= 4);
      present(1'b1, c_NOP);
      step();
      check("wrap_tag",   32'(rob_tag),   32'(i % 16));
      check("wrap_count", 32'(rob_count), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    rob_commit = 1'b0;

    // Asynchronous reset while an alloc pulse is high
    present(1'b1, c_NOP);
    step();
    dec_valid = 1'b0;
    check("ar_pre_alloc", 32'(rob_alloc), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_alloc", 32'(rob_alloc), 32'd0);
    check("ar_tag",   32'(rob_tag),   32'd0);
    check("ar_count", 32'(rob_count), 32'd0);
    check("ar_stall", 32'(stall_cnt), 32'd0);
    check("ar_empty", 32'(rob_empty), 32'd1);
    #2 rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
